// File: rtl/cmd_dispatcher.sv
// Command dispatcher: decodes UART opcodes and sequences the write,
// read-back and acquisition controllers with an idle watchdog.
module cmd_dispatcher #(
  parameter logic [7:0]  CMD_WR   = 8'h57,
  parameter logic [7:0]  CMD_RD   = 8'h52,
  parameter logic [7:0]  CMD_RUN  = 8'h53,
  parameter logic [7:0]  CMD_STOP = 8'h50,
  parameter logic [15:0] TIMEOUT  = 16'd50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rxrdy,
  input  logic       done_wr,
  input  logic       done_rd,
  output logic       start_wr,
  output logic       start_rd,
  output logic       run_en,
  output logic       sub_rst,
  output logic       cmd_ack,
  output logic       err,
  output logic [2:0] state_leds
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        ack_q, ack_d;
  logic        strd_q, strd_d;
  logic        sub_q, sub_d;
  logic        tmo;
  logic [15:0] cnt_inc;

  assign tmo     = (cnt_q >= (TIMEOUT - 16'd1));
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ack_d   = 1'b0;
    strd_d  = 1'b0;
    sub_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = 16'd0;
        if (rxrdy) begin
          if (rx_data == CMD_WR) begin
            state_d = S_WR;
            ack_d   = 1'b1;
            err_d   = 1'b0;
          end else if (rx_data == CMD_RD) begin
            state_d = S_RD;
            ack_d   = 1'b1;
            strd_d  = 1'b1;
            err_d   = 1'b0;
          end else if (rx_data == CMD_RUN) begin
            state_d = S_RUN;
            ack_d   = 1'b1;
            err_d   = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_WR: begin
        // done wins over a coincident watchdog expiry
        if (done_wr) begin
          state_d = S_IDLE;
        end else if (tmo) begin
          state_d = S_IDLE;
          sub_d   = 1'b1;
          err_d   = 1'b1;
        end else if (rxrdy) begin
          cnt_d = 16'd0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RD: begin
        if (done_rd) begin
          state_d = S_IDLE;
        end else if (tmo) begin
          state_d = S_IDLE;
          sub_d   = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RUN: begin
        if (rxrdy && (rx_data == CMD_STOP)) state_d = S_IDLE;
      end
      S_ERR: begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      err_q   <= 1'b0;
      ack_q   <= 1'b0;
      strd_q  <= 1'b0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
      strd_q  <= strd_d;
      sub_q   <= sub_d;
    end
  end

  assign start_wr   = (state_q == S_WR);
  assign run_en     = (state_q == S_RUN);
  assign start_rd   = strd_q;
  assign sub_rst    = sub_q;
  assign cmd_ack    = ack_q;
  assign err        = err_q;
  assign state_leds = state_q;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Bench for cmd_dispatcher: directed scenarios plus random traffic,
// every cycle compared against a deadline-based reference model.
module tb_cmd_dispatcher;

  localparam int T = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rxrdy;
  logic       done_wr;
  logic       done_rd;
  logic       start_wr;
  logic       start_rd;
  logic       run_en;
  logic       sub_rst;
  logic       cmd_ack;
  logic       err;
  logic [2:0] state_leds;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cmd_dispatcher #(.TIMEOUT(16'd100)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rxrdy(rxrdy),
    .done_wr(done_wr), .done_rd(done_rd),
    .start_wr(start_wr), .start_rd(start_rd), .run_en(run_en),
    .sub_rst(sub_rst), .cmd_ack(cmd_ack), .err(err),
    .state_leds(state_leds)
  );

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 write, 2 read, 3 run, 4 error.
  // Watchdog tracked as the cycle of last activity, not a counter.
  int     m_mode = 0;
  longint m_cyc  = 0;
  longint m_last = 0;
  bit     m_err = 0, m_ack = 0, m_strd = 0, m_sub = 0;

  function automatic logic [15:0] m_out();
    return {7'd0, m_mode == 1, m_strd, m_mode == 3, m_sub, m_ack, m_err,
            3'(m_mode)};
  endfunction

  function automatic logic [15:0] d_out();
    return {7'd0, start_wr, start_rd, run_en, sub_rst, cmd_ack, err,
            state_leds};
  endfunction

  task automatic model_step(input bit r, input bit rr, input byte d,
                            input bit dw, input bit dr);
    bit expired;
    m_cyc++;
    expired = (m_cyc - m_last) >= T;
    m_ack = 0; m_strd = 0; m_sub = 0;
    if (r) begin
      m_mode = 0; m_err = 0;
    end else if (m_mode == 0) begin
      m_last = m_cyc;
      if (rr) begin
        if (d == 8'h57 || d == 8'h52 || d == 8'h53) begin
          m_mode = (d == 8'h57) ? 1 : (d == 8'h52) ? 2 : 3;
          m_ack = 1; m_err = 0; m_strd = (d == 8'h52);
        end else begin
          m_mode = 4; m_err = 1;
        end
      end
    end else if (m_mode == 1 || m_mode == 2) begin
      if ((m_mode == 1 && dw) || (m_mode == 2 && dr)) m_mode = 0;
      else if (expired) begin
        m_mode = 0; m_sub = 1; m_err = 1;
      end else if (m_mode == 1 && rr) m_last = m_cyc;
    end else if (m_mode == 3) begin
      if (rr && d == 8'h50) m_mode = 0;
    end else begin
      m_mode = 0; m_err = 1;
    end
  endtask

  task automatic tick(input bit r, input bit rr, input byte d,
                      input bit dw, input bit dr);
    rst = r; rxrdy = rr; rx_data = d; done_wr = dw; done_rd = dr;
    @(posedge clk);
    model_step(r, rr, d, dw, dr);
    @(negedge clk);
    chk("outputs", d_out(), m_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 8'h00, 0, 0);
  endtask

  task automatic byte_in(input byte d);
    tick(0, 1, d, 0, 0);
  endtask

  initial begin
    int n;
    byte b;
    rst = 1; rxrdy = 0; rx_data = 0; done_wr = 0; done_rd = 0;
    tick(1, 0, 8'h00, 0, 0);
    chk("reset", d_out(), 16'd0);
    idle(2);

    // write sequence with data bytes
    byte_in(8'h57);
    chk("wr_ack", {15'd0, cmd_ack}, 16'd1);
    for (int i = 0; i < 11; i++) byte_in(8'($urandom));
    tick(0, 0, 8'h00, 1, 0);
    chk("wr_done_leds", {13'd0, state_leds}, 16'd0);
    idle(2);

    // read-back
    byte_in(8'h52);
    chk("rd_start", {15'd0, start_rd}, 16'd1);
    idle(19);
    tick(0, 0, 8'h00, 0, 1);
    chk("rd_idle_err", {12'd0, err, state_leds}, 16'd0);

    // watchdog expiry
    byte_in(8'h57);
    byte_in(8'h11);
    byte_in(8'h22);
    n = 0;
    while (n < 200) begin
      idle(1);
      n++;
      if (sub_rst) break;
    end
    chk("tmo_latency", 16'(n), 16'd100);
    chk("tmo_err", {15'd0, err}, 16'd1);
    idle(1);

    // invalid opcode then run / stop
    byte_in(8'h41);
    chk("bad_leds", {13'd0, state_leds}, 16'd4);
    idle(3);
    chk("err_sticky", {15'd0, err}, 16'd1);
    byte_in(8'h53);
    chk("run_en", {14'd0, run_en, err}, 16'd2);
    byte_in(8'h57);
    chk("run_hold", {15'd0, run_en}, 16'd1);
    byte_in(8'h50);
    chk("run_stop", {14'd0, run_en, cmd_ack}, 16'd0);

    // done coincident with watchdog expiry
    byte_in(8'h57);
    idle(T - 1);
    tick(0, 0, 8'h00, 1, 0);
    chk("done_vs_tmo", {11'd0, sub_rst, err, state_leds}, 16'd0);

    // reset mid-write
    byte_in(8'h57);
    idle(5);
    tick(1, 1, 8'h52, 1, 1);
    chk("rst_mid_wr", d_out(), 16'd0);

    // random traffic
    for (int c = 0; c < 6000; c++) begin
      case ($urandom_range(0, 5))
        0: b = 8'h57;
        1: b = 8'h52;
        2: b = 8'h53;
        3: b = 8'h50;
        4: b = 8'h41;
        default: b = 8'($urandom);
      endcase
      tick($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0, b,
           $urandom_range(0, 29) == 0, $urandom_range(0, 39) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
